universal_shift_reg: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with async clear/preset,

---
 rtl/usr_pkg.sv | 20 ++
 rtl/dff_cell.sv | 31 +++
 rtl/universal_shift_reg.sv | 102 ++++++++++
 tb/tb_universal_shift_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operating modes and counter sizing.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    ROR  = 3'b011,
    ROL  = 3'b100,
    LOAD = 3'b101,
    ASR  = 3'b110,
    CLR  = 3'b111
  } mode_t;

  // Width needed to hold a shift count of 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_cell.sv
// One register bit: rising-edge D flip-flop with asynchronous active-low clear and preset,
// clear taking priority over preset.
module dff_cell #(
  parameter logic CLR_VAL = 1'b0,
  parameter logic PRE_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic pre_n,
  input  logic d,
  output logic q
);

  // Preset is masked while clear is active, so releasing clear with preset still low
  // produces a falling edge here and the preset value is applied without a clock.
  logic pre_eff_n;
  assign pre_eff_n = pre_n | ~clr_n;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples its inputs before any of them update on the same edge.
  always_ff @(posedge clk or negedge clr_n or negedge pre_eff_n) begin
    if (!clr_n) begin
      q <= CLR_VAL;
    end else if (!pre_eff_n) begin
      q <= PRE_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: eight operating modes, clock enable,
// async clear/preset, saturating shift counter and a one-cycle done pulse.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1,
  localparam int              CW          = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  mode_t            op;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             done_next;
  logic             arst_n;

  assign op = mode_t'(mode);

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    q_next = q;
    if (en) begin
      unique case (op)
        HOLD: q_next = q;
        SHR:  q_next = {sin_r, q[WIDTH-1:1]};
        SHL:  q_next = {q[WIDTH-2:0], sin_l};
        ROR:  q_next = {q[0], q[WIDTH-1:1]};
        ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        LOAD: q_next = d;
        ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
        CLR:  q_next = '0;
        default: q_next = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell #(
      .CLR_VAL(RESET_VALUE[i]),
      .PRE_VAL(SET_VALUE[i])
    ) u_cell (
      .clk  (clk),
      .clr_n(reset),
      .pre_n(set),
      .d    (q_next[i]),
      .q    (q[i])
    );
  end

  assign qbar   = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  // The counter saturates at WIDTH, so done fires only on the WIDTH-1 -> WIDTH step.
  always_comb begin
    cnt_next  = shift_cnt;
    done_next = 1'b0;
    if (en) begin
      unique case (op)
        SHR, SHL, ROR, ROL, ASR: begin
          if (shift_cnt != CW'(WIDTH)) begin
            cnt_next  = shift_cnt + CW'(1);
            done_next = (shift_cnt == CW'(WIDTH - 1));
          end
        end
        LOAD, CLR: cnt_next = '0;
        default:   cnt_next = shift_cnt;
      endcase
    end
  end

  // Reset and set both force the counter and done to zero.
  assign arst_n = reset & set;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      shift_cnt <= cnt_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       reset, set, en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_r, sin_l;
  logic [7:0] q, qbar;
  logic       sout_r, sout_l;
  logic [3:0] shift_cnt;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .set      (set),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .q        (q),
    .qbar     (qbar),
    .sout_r   (sout_r),
    .sout_l   (sout_l),
    .shift_cnt(shift_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    en   = 1'b1;
    mode = LOAD;
    d    = v;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; set = 1'b1; en = 1'b1; mode = HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    #3;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
    n_checks++;
    if (qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar: got %h want ff", qbar); end
    n_checks++;
    if (shift_cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt: cnt=%0d done=%b want 0/0", shift_cnt, done);
    end
    tick();
    reset = 1'b1;
    tick();
    do_load(8'hA5);
    n_checks++;
    if (q !== 8'hA5 || sout_r !== 1'b1 || sout_l !== 1'b1) begin
      n_fail++; $display("FAIL load_a5: q=%h sr=%b sl=%b want a5/1/1", q, sout_r, sout_l);
    end
    // Assert reset mid-cycle: must clear without a clock edge.
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00 || shift_cnt !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: q=%h cnt=%0d want 00/0", q, shift_cnt);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_shr();
    logic [7:0] exp_q;
    logic [7:0] a5;
    a5 = 8'hA5;
    do_load(a5);
    exp_q = a5;
    n_checks++;
    if (shift_cnt !== 4'd0) begin n_fail++; $display("FAIL shr_cnt0: got %0d want 0", shift_cnt); end
    mode = SHR; sin_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sout_r !== a5[i]) begin
        n_fail++; $display("FAIL shr_sout_r[%0d]: got %b want %b", i, sout_r, a5[i]);
      end
      tick();
      exp_q = {1'b1, exp_q[7:1]};
      n_checks++;
      if (q !== exp_q || done !== (i == 7)) begin
        n_fail++; $display("FAIL shr_step[%0d]: q=%h done=%b want %h/%b", i, q, done, exp_q, (i == 7));
      end
    end
    n_checks++;
    if (q !== 8'hFF || shift_cnt !== 4'd8) begin
      n_fail++; $display("FAIL shr_final: q=%h cnt=%0d want ff/8", q, shift_cnt);
    end
    tick();
    n_checks++;
    if (shift_cnt !== 4'd8 || done !== 1'b0) begin
      n_fail++; $display("FAIL shr_saturate: cnt=%0d done=%b want 8/0", shift_cnt, done);
    end
  endtask

  task automatic test_rotate_arith();
    do_load(8'h81); mode = ROL; tick();
    n_checks++;
    if (q !== 8'h03) begin n_fail++; $display("FAIL rol: got %h want 03", q); end
    do_load(8'h81); mode = ROR; tick();
    n_checks++;
    if (q !== 8'hC0) begin n_fail++; $display("FAIL ror: got %h want c0", q); end
    do_load(8'h80); mode = ASR; tick();
    n_checks++;
    if (q !== 8'hC0 || shift_cnt !== 4'd1) begin
      n_fail++; $display("FAIL asr: q=%h cnt=%0d want c0/1", q, shift_cnt);
    end
    do_load(8'h80); sin_l = 1'b1; mode = SHL; tick();
    n_checks++;
    if (q !== 8'h01) begin n_fail++; $display("FAIL shl: got %h want 01", q); end
    n_checks++;
    if (qbar !== 8'hFE || sout_l !== 1'b0 || sout_r !== 1'b1) begin
      n_fail++; $display("FAIL shl_outs: qbar=%h sl=%b sr=%b want fe/0/1", qbar, sout_l, sout_r);
    end
    do_load(8'h5A); mode = HOLD; tick();
    n_checks++;
    if (q !== 8'h5A) begin n_fail++; $display("FAIL hold: got %h want 5a", q); end
  endtask

  task automatic test_reset_set();
    do_load(8'h3C);
    mode = SHR; sin_r = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (q !== 8'h07 || shift_cnt !== 4'd3) begin
      n_fail++; $display("FAIL pre_rs: q=%h cnt=%0d want 07/3", q, shift_cnt);
    end
    mode = HOLD;
    #1 reset = 1'b0; set = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00 || shift_cnt !== 4'd0) begin
      n_fail++; $display("FAIL both_low: q=%h cnt=%0d want 00/0", q, shift_cnt);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (q !== 8'hFF) begin n_fail++; $display("FAIL set_after_reset: got %h want ff", q); end
    #1 set = 1'b1;
    #1;
    n_checks++;
    if (q !== 8'hFF || shift_cnt !== 4'd0) begin
      n_fail++; $display("FAIL set_release: q=%h cnt=%0d want ff/0", q, shift_cnt);
    end
    mode = LOAD; d = 8'h5A;
    tick();
    n_checks++;
    if (q !== 8'h5A) begin n_fail++; $display("FAIL post_set_load: got %h want 5a", q); end
  endtask

  task automatic test_enable();
    do_load(8'h5A);
    mode = SHL; sin_l = 1'b0;
    tick(); tick();
    n_checks++;
    if (q !== 8'h68 || shift_cnt !== 4'd2) begin
      n_fail++; $display("FAIL en_pre: q=%h cnt=%0d want 68/2", q, shift_cnt);
    end
    en = 1'b0; mode = LOAD; d = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (q !== 8'h68 || shift_cnt !== 4'd2 || done !== 1'b0) begin
        n_fail++; $display("FAIL en_hold[%0d]: q=%h cnt=%0d done=%b want 68/2/0", i, q, shift_cnt, done);
      end
    end
    // Disabled edge at count 7 must not advance the counter or pulse done.
    do_load(8'h00);
    mode = SHR; sin_r = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    en = 1'b0;
    tick();
    n_checks++;
    if (shift_cnt !== 4'd7 || done !== 1'b0 || q !== 8'hFE) begin
      n_fail++; $display("FAIL en_at7: q=%h cnt=%0d done=%b want fe/7/0", q, shift_cnt, done);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (shift_cnt !== 4'd8 || done !== 1'b1) begin
      n_fail++; $display("FAIL en_resume: cnt=%0d done=%b want 8/1", shift_cnt, done);
    end
  endtask

  task automatic test_clr_rearm();
    int pulses;
    do_load(8'hFF);
    mode = SHR; sin_r = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (q !== 8'h07 || shift_cnt !== 4'd5) begin
      n_fail++; $display("FAIL clr_pre: q=%h cnt=%0d want 07/5", q, shift_cnt);
    end
    mode = CLR; tick();
    n_checks++;
    if (q !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL clr: q=%h cnt=%0d done=%b want 00/0/0", q, shift_cnt, done);
    end
    pulses = 0;
    mode = SHL; sin_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL clr_rearm_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (q !== 8'hFF || shift_cnt !== 4'd8) begin
      n_fail++; $display("FAIL clr_rearm_final: q=%h cnt=%0d want ff/8", q, shift_cnt);
    end
    mode = HOLD; tick();
    n_checks++;
    if (shift_cnt !== 4'd8 || done !== 1'b0) begin
      n_fail++; $display("FAIL hold_cnt: cnt=%0d done=%b want 8/0", shift_cnt, done);
    end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_rotate_arith();
    test_reset_set();
    test_enable();
    test_clr_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
